// File: rtl/kernel_ctrl_pkg.sv
// Shared types and constants for the kernel sequencing controllers.
package kernel_ctrl_pkg;

  // Default width of item counters and the job item count.
  localparam int KSC_CNTW = 32;

  // Job sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ksc_state_t;

endpackage

// File: rtl/valid_tracker.sv
// Valid-bit shadow of a fixed-latency, stall-able kernel pipeline.
// One bit per kernel stage; it moves only when the kernel advances, so
// vout marks whether the word leaving the kernel is a real result.
module valid_tracker #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic rst,   // asynchronous, active low
  input  logic adv,   // kernel advances this cycle
  input  logic vin,   // a real word enters stage 0 on this advance
  input  logic clr,   // job start: forget everything in flight
  output logic vout
);

  logic [LAT-1:0] r_vpipe;

  // Shift the valid bits in lock-step with the kernel; hold while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vpipe <= '0;
    end else if (clr) begin
      r_vpipe <= '0;
    end else if (adv) begin
      for (int i = LAT - 1; i > 0; i--) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end
      r_vpipe[0] <= vin;
    end
  end

  assign vout = r_vpipe[LAT-1];

endmodule

// File: rtl/kernel_stream_ctrl.sv
// Job sequencer for a fixed-latency, stall-able map kernel. Admits N input
// words, drives the kernel stall, tags real results and pulses done once
// all N results have been delivered. Carries no data itself.
//
// Handshakes: a word transfers in any cycle where valid and ready are both
// high; valid never depends on ready of the same port, ready may depend on
// the other side (in_ready drops combinationally under output backpressure).
//
// Optional build macro KSC_PERF_CNT_EN adds the stall_cycles and
// bubble_cycles performance counters.
module kernel_stream_ctrl
  import kernel_ctrl_pkg::*;
#(
  parameter int LAT  = 4,
  parameter int CNTW = KSC_CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CNTW-1:0] nitems,
  output logic            busy,
  output logic            done,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            krn_stall,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CNTW-1:0] cnt_in,
  output logic [CNTW-1:0] cnt_out,
`ifdef KSC_PERF_CNT_EN
  output logic [31:0]     stall_cycles,
  output logic [31:0]     bubble_cycles,
`endif
  output ksc_state_t      dbg_state
);

  ksc_state_t      r_state;
  ksc_state_t      w_next;
  logic [CNTW-1:0] r_n;
  logic [CNTW-1:0] r_cnt_in;
  logic [CNTW-1:0] r_cnt_out;
  logic            w_active;
  logic            w_adv;
  logic            w_in_hs;
  logic            w_out_hs;
  logic            w_job_start;
  logic            w_vout;

  assign w_job_start = (r_state == IDLE) && start;
  assign w_active    = (r_state == RUN) || (r_state == DRAIN);
  // A held result that downstream refuses freezes the whole kernel.
  assign w_adv       = w_active && !(w_vout && !out_ready);
  assign krn_stall   = !w_adv;
  assign in_ready    = (r_state == RUN) && w_adv && (r_cnt_in < r_n);
  assign out_valid   = w_vout;
  assign w_in_hs     = in_valid && in_ready;
  assign w_out_hs    = w_vout && out_ready;
  assign cnt_in      = r_cnt_in;
  assign cnt_out     = r_cnt_out;
  assign dbg_state   = r_state;

  valid_tracker #(.LAT(LAT)) u_valid_tracker (
    .clk  (clk),
    .rst  (rst),
    .adv  (w_adv),
    .vin  (w_in_hs),
    .clr  (w_job_start),
    .vout (w_vout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state and status outputs. DRAIN exits on the cycle the last
  // result leaves, so done follows the final output by exactly one cycle.
  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = (nitems == '0) ? DONE : RUN;
      end
      RUN: begin
        if (r_cnt_in == r_n) w_next = DRAIN;
      end
      DRAIN: begin
        if ((r_cnt_out == r_n) || (w_out_hs && (r_cnt_out + CNTW'(1) == r_n)))
          w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Job length and item counters; values persist after the job ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n       <= '0;
      r_cnt_in  <= '0;
      r_cnt_out <= '0;
    end else if (w_job_start) begin
      r_n       <= nitems;
      r_cnt_in  <= '0;
      r_cnt_out <= '0;
    end else begin
      if (w_in_hs)  r_cnt_in  <= r_cnt_in + CNTW'(1);
      if (w_out_hs) r_cnt_out <= r_cnt_out + CNTW'(1);
    end
  end

`ifdef KSC_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_bubble_cycles;

  // Saturating counts of frozen cycles and of advancing RUN cycles
  // that admitted no word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles  <= '0;
      r_bubble_cycles <= '0;
    end else if (w_job_start) begin
      r_stall_cycles  <= '0;
      r_bubble_cycles <= '0;
    end else begin
      if (w_active && !w_adv && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if ((r_state == RUN) && w_adv && !w_in_hs && (r_bubble_cycles != '1))
        r_bubble_cycles <= r_bubble_cycles + 32'd1;
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign bubble_cycles = r_bubble_cycles;
`endif

endmodule

// File: tb/tb_kernel_stream_ctrl.sv
// Bench for kernel_stream_ctrl. A behavioural stall-able kernel sits beside
// the controller; words admitted are pushed as expected results and popped
// when the controller marks a kernel output valid and downstream takes it.
module tb_kernel_stream_ctrl;
  import kernel_ctrl_pkg::*;

  localparam int LAT  = 4;
  localparam int CNTW = 32;
  localparam int DW   = 16;
  localparam int MAXC = 64;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CNTW-1:0] nitems;
  logic            busy, done, in_valid, in_ready, krn_stall, out_valid, out_ready;
  logic [CNTW-1:0] cnt_in, cnt_out;
  ksc_state_t      dbg_state;
`ifdef KSC_PERF_CNT_EN
  logic [31:0]     stall_cycles, bubble_cycles;
`endif

  always #5 clk = ~clk;

  kernel_stream_ctrl #(.LAT(LAT), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .nitems    (nitems),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .krn_stall (krn_stall),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_in    (cnt_in),
    .cnt_out   (cnt_out),
`ifdef KSC_PERF_CNT_EN
    .stall_cycles  (stall_cycles),
    .bubble_cycles (bubble_cycles),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- kernel model ----------------
  logic [DW-1:0] in_data;
  logic [DW-1:0] kpipe [LAT];

  function automatic logic [DW-1:0] kfun(input logic [DW-1:0] x);
    return x * DW'(3) + DW'(1);
  endfunction

  always @(posedge clk) begin
    if (!krn_stall) begin
      kpipe[0] <= kfun(in_data);
      for (int i = 1; i < LAT; i++) kpipe[i] <= kpipe[i-1];
    end
  end

  // ---------------- scoreboard and per-job logs ----------------
  logic [DW-1:0]   exp_q[$];
  int              errors = 0;
  int              checks = 0;
  logic            ov_log [MAXC];
  logic            ks_log [MAXC];
  logic            ir_log [MAXC];
  logic            busy_log [MAXC];
  int              done_cyc, first_ov, n_out;
  logic [CNTW-1:0] cin_done, cout_done;
  logic [31:0]     stall_done, bubble_done;

  // One clock cycle: drive at negedge, sample 1 time unit later.
  task automatic run_cycle(input int c, input logic iv, input logic ordy,
                           input logic st, input logic [CNTW-1:0] n);
    logic [DW-1:0] exp;
    @(negedge clk);
    start     = st;
    nitems    = n;
    in_valid  = iv;
    out_ready = ordy;
    in_data   = DW'($urandom_range(0, 65535));
    #1;
    if (c < MAXC) begin
      ov_log[c]   = out_valid;
      ks_log[c]   = krn_stall;
      ir_log[c]   = in_ready;
      busy_log[c] = busy;
    end
    if (out_valid === 1'b1 && first_ov < 0) first_ov = c;
    if (in_valid && in_ready) exp_q.push_back(kfun(in_data));
    if (out_valid && out_ready) begin
      n_out++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: cycle %0d output with nothing expected", c);
      end else begin
        exp = exp_q.pop_front();
        if (kpipe[LAT-1] !== exp) begin
          errors++;
          $display("FAIL out_data: cycle %0d got %h expected %h", c, kpipe[LAT-1], exp);
        end
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL done_with_out_valid: cycle %0d out_valid=%b expected 0", c, out_valid);
      end
      if (done_cyc < 0) begin
        done_cyc  = c;
        cin_done  = cnt_in;
        cout_done = cnt_out;
`ifdef KSC_PERF_CNT_EN
        stall_done  = stall_cycles;
        bubble_done = bubble_cycles;
`endif
      end
    end
  endtask

  // One job. mode 0: in_valid always high; mode 1: high on odd cycles.
  // out_ready is low in [bp_start, bp_start+bp_len). xs_cyc raises start
  // again mid-job. stop < MAXC abandons the job after cycle stop-1.
  task automatic run_job(input logic [CNTW-1:0] n, input int mode, input int bp_start,
                         input int bp_len, input int xs_cyc, input int stop);
    logic iv, ordy, st;
    logic [CNTW-1:0] nn;
    done_cyc = -1; first_ov = -1; n_out = 0;
    for (int i = 0; i < MAXC; i++) begin
      ov_log[i] = 1'b0; ks_log[i] = 1'b0; ir_log[i] = 1'b0; busy_log[i] = 1'b0;
    end
    for (int c = 0; c < stop; c++) begin
      st   = (c == 0) || (c == xs_cyc);
      nn   = (c == 0) ? n : CNTW'(1);
      iv   = (mode == 0) ? 1'b1 : ((c % 2) == 1);
      ordy = !((c >= bp_start) && (c < bp_start + bp_len));
      run_cycle(c, iv, ordy, st, nn);
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0;
    if (stop >= MAXC) begin
      checks++;
      if (done_cyc < 0) begin
        errors++;
        $display("FAIL job_timeout: no done within %0d cycles for N=%0d", MAXC, n);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; start = 1'b0; nitems = '0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, in_ready, krn_stall, out_valid} !== 5'b00010) begin
      errors++;
      $display("FAIL reset_outputs: busy/done/in_ready/stall/out_valid=%b expected 00010",
               {busy, done, in_ready, krn_stall, out_valid});
    end
    checks++;
    if (cnt_in !== '0 || cnt_out !== '0) begin
      errors++;
      $display("FAIL reset_counters: cnt_in=%0d cnt_out=%0d expected 0 0", cnt_in, cnt_out);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_nominal();
    int bad_ov, bad_ks;
    run_job(CNTW'(8), 0, -1, 0, 3, MAXC);
    checks++;
    if (first_ov !== 5) begin
      errors++; $display("FAIL nom_first_out: cycle %0d expected 5", first_ov);
    end
    checks++;
    if (done_cyc !== 13) begin
      errors++; $display("FAIL nom_done_cycle: cycle %0d expected 13", done_cyc);
    end
    bad_ov = 0; bad_ks = 0;
    for (int c = 5; c <= 12; c++) if (ov_log[c] !== 1'b1) bad_ov++;
    if (ov_log[13] !== 1'b0) bad_ov++;
    for (int c = 1; c <= 12; c++) if (ks_log[c] !== 1'b0) bad_ks++;
    checks++;
    if (bad_ov != 0) begin
      errors++; $display("FAIL nom_out_window: %0d cycles off expected outputs 5..12", bad_ov);
    end
    checks++;
    if (bad_ks != 0) begin
      errors++; $display("FAIL nom_no_stall: %0d stalled cycles in 1..12 expected 0", bad_ks);
    end
    checks++;
    if (ks_log[0] !== 1'b1 || busy_log[0] !== 1'b0 || busy_log[1] !== 1'b1) begin
      errors++;
      $display("FAIL nom_idle_run: stall0=%b busy0=%b busy1=%b expected 1 0 1",
               ks_log[0], busy_log[0], busy_log[1]);
    end
    checks++;
    if (n_out != 8 || cin_done !== CNTW'(8) || cout_done !== CNTW'(8)) begin
      errors++;
      $display("FAIL nom_counts: outs=%0d cnt_in=%0d cnt_out=%0d expected 8 8 8",
               n_out, cin_done, cout_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL nom_leftover: %0d results undelivered expected 0", exp_q.size());
    end
`ifdef KSC_PERF_CNT_EN
    checks++;
    if (stall_done !== 32'd0 || bubble_done !== 32'd1) begin
      errors++;
      $display("FAIL nom_perf: stall=%0d bubble=%0d expected 0 1", stall_done, bubble_done);
    end
`endif
  endtask

  task automatic test_zero_items();
    int bad;
    run_job(CNTW'(0), 0, -1, 0, -1, MAXC);
    checks++;
    if (done_cyc !== 1) begin
      errors++; $display("FAIL zero_done_cycle: cycle %0d expected 1", done_cyc);
    end
    bad = 0;
    for (int c = 0; c <= 3; c++)
      if (ir_log[c] !== 1'b0 || ov_log[c] !== 1'b0 || ks_log[c] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL zero_quiet: %0d cycles with ready/valid/no-stall expected 0", bad);
    end
    checks++;
    if (n_out != 0 || cin_done !== '0 || cout_done !== '0) begin
      errors++;
      $display("FAIL zero_counts: outs=%0d cnt_in=%0d cnt_out=%0d expected 0 0 0",
               n_out, cin_done, cout_done);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    run_job(CNTW'(6), 0, 6, 3, -1, MAXC);
    bad = 0;
    for (int c = 6; c <= 8; c++)
      if (ov_log[c] !== 1'b1 || ks_log[c] !== 1'b1 || ir_log[c] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_stall: %0d of 3 held cycles not stalled expected 0", bad);
    end
    checks++;
    if (n_out != 6 || cout_done !== CNTW'(6) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_counts: outs=%0d cnt_out=%0d left=%0d expected 6 6 0",
               n_out, cout_done, exp_q.size());
    end
    checks++;
    if (done_cyc !== 14) begin
      errors++; $display("FAIL bp_done_cycle: cycle %0d expected 14", done_cyc);
    end
`ifdef KSC_PERF_CNT_EN
    checks++;
    if (stall_done !== 32'd3) begin
      errors++; $display("FAIL bp_stall_cycles: got %0d expected 3", stall_done);
    end
`endif
  endtask

  task automatic test_alternating();
    int n_ov;
    run_job(CNTW'(5), 1, -1, 0, -1, MAXC);
    n_ov = 0;
    for (int c = 0; c < MAXC; c++) if (ov_log[c] === 1'b1) n_ov++;
    checks++;
    if (n_ov != 5 || n_out != 5) begin
      errors++; $display("FAIL alt_outputs: valid=%0d taken=%0d expected 5 5", n_ov, n_out);
    end
    checks++;
    if (cin_done !== CNTW'(5) || cout_done !== CNTW'(5) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL alt_counts: cnt_in=%0d cnt_out=%0d left=%0d expected 5 5 0",
               cin_done, cout_done, exp_q.size());
    end
    checks++;
    if (done_cyc !== 14) begin
      errors++; $display("FAIL alt_done_cycle: cycle %0d expected 14", done_cyc);
    end
  endtask

  task automatic test_reset_mid_drain();
    int seen_done;
    run_job(CNTW'(8), 0, -1, 0, -1, 11);
    checks++;
    if (busy !== 1'b1 || dbg_state !== DRAIN) begin
      errors++; $display("FAIL rst_pre_drain: busy=%b state=%0d expected 1 DRAIN", busy, dbg_state);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, in_ready, krn_stall, out_valid} !== 5'b00010 ||
        cnt_in !== '0 || cnt_out !== '0) begin
      errors++;
      $display("FAIL rst_async: flags=%b cnt_in=%0d cnt_out=%0d expected 00010 0 0",
               {busy, done, in_ready, krn_stall, out_valid}, cnt_in, cnt_out);
    end
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (done !== 1'b0) seen_done++;
    end
    checks++;
    if (seen_done != 0 || done_cyc >= 0) begin
      errors++; $display("FAIL rst_no_done: %0d done pulses expected 0", seen_done);
    end
    rst = 1'b1;
    exp_q.delete();
    run_job(CNTW'(3), 0, -1, 0, -1, MAXC);
    checks++;
    if (done_cyc !== 8 || n_out != 3 || cout_done !== CNTW'(3) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_rejob: done=%0d outs=%0d cnt_out=%0d expected 8 3 3",
               done_cyc, n_out, cout_done);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_items();
    test_backpressure();
    test_alternating();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kernel_stream_ctrl.md
# kernel_stream_ctrl

Sequencing controller for a fixed-latency, stall-able map kernel such as the top-level kernel wrappers. It accepts a job of N work items, admits input words with a valid/ready handshake, and drives the kernel's `stall` input. It tracks which pipeline slots hold real data, presents results downstream with valid/ready, and pulses `done` when all N results have left. It carries no data; the data path runs directly between the stream ports and the kernel.

## Interface
- `LAT`, default 4: kernel pipeline latency in cycles, ≥1.
- `CNTW`, default 32: width of item counters and `nitems`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: job start request, sampled only in IDLE.
- `nitems` in CNTW: item count for the job, latched on accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in the DONE state.
- `in_valid` in 1: upstream word valid.
- `in_ready` out 1: controller admits a word this cycle.
- `krn_stall` out 1: wired to the kernel `stall` input.
- `out_valid` out 1: kernel output word is a real result.
- `out_ready` in 1: downstream accepts.
- `cnt_in` out CNTW: items admitted in the current job.
- `cnt_out` out CNTW: items delivered in the current job.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE:
  - `start`=1 latches `nitems` into `n_q` and clears both counters.
  - Goes to RUN, or to DONE if `nitems`==0.
- RUN goes to DRAIN in the cycle after `cnt_in` reaches `n_q`.
- DRAIN goes to DONE when `cnt_out` reaches `n_q`.
- DONE lasts one cycle: `done`=1, then IDLE.
- `start` is ignored outside IDLE.
- Valid tracker: `vpipe[LAT-1:0]`, one bit per kernel stage. `out_valid` = `vpipe[LAT-1]`.
- Advance condition: `adv` = (state is RUN or DRAIN) and not (`out_valid` and not `out_ready`).
- `krn_stall` = not `adv`. The kernel is frozen in IDLE and DONE.
- When `adv`=1:
  - `vpipe` shifts by one.
  - `vpipe[0]` takes `in_valid` and `in_ready`.
  - An empty input slot becomes a bubble, with `vpipe[0]`=0.
- When `adv`=0, `vpipe` holds.
- `in_ready` = (state==RUN) and `adv` and (`cnt_in` < `n_q`).
- `cnt_in` increments on each input handshake. `cnt_out` increments on each output handshake (`out_valid` and `out_ready`).
- Counters and `vpipe` clear on job start.
- Counters hold their final values through DONE and IDLE until the next start.
- Counters compare unsigned at CNTW bits and never wrap, because admission stops at `n_q`.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `in_ready`=0, `krn_stall`=1, `out_valid`=0.
  - `cnt_in`=0, `cnt_out`=0, `vpipe`=0, state IDLE.
- Reset is asynchronous at any point; an in-flight job is abandoned with no `done`.
- `start` at cycle t puts the controller in RUN at t+1. The earliest input handshake is at t+1.
- Input accepted at cycle a: `out_valid`=1 at a+LAT plus the number of stall cycles in between.
- Output backpressure (`out_valid`=1, `out_ready`=0) asserts `krn_stall` and drops `in_ready` in the same cycle, combinationally.
- A simultaneous input and output handshake in one cycle is legal; both counters increment.
- Minimum job duration with no stalls and continuous `in_valid`: N+LAT+1 cycles from `start` to `done`.
- `done` is never asserted in the same cycle as `out_valid`.

## Configuration
- `KSC_PERF_CNT_EN` defined:
  - Adds output `stall_cycles`, 32 bits, counting cycles in RUN/DRAIN with `krn_stall`=1.
  - Adds output `bubble_cycles`, 32 bits, counting RUN cycles with `adv`=1 and no input handshake.
  - Both clear on job start and reset, and saturate at all-ones.
- Undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- Package `kernel_ctrl_pkg`: state enum `ksc_state_t` (IDLE, RUN, DRAIN, DONE) and the default `CNTW` constant.
- Sub-module `valid_tracker`:
  - Parameter `LAT`.
  - Inputs: `adv`, `vin`, `clr`.
  - Output: `vout`, which is the last stage of `vpipe`.
  - Reused by other kernel controllers.

## Test plan
- LAT=4, N=8, `in_valid` and `out_ready` tied high, `start` at cycle 0 → first `out_valid` at cycle 5, eight consecutive outputs, `done` at cycle 13, `krn_stall`=0 throughout cycles 1–12.
- N=0 → `done` one cycle after `start`; `in_ready` and `out_valid` stay 0; `krn_stall` stays 1.
- N=6, `out_ready` low for 3 cycles while `out_valid`=1 → `krn_stall`=1 and `in_ready`=0 for those 3 cycles; no output lost or duplicated; `cnt_out` ends at 6.
- N=5, `in_valid` alternating 1/0 → bubbles never raise `out_valid`; exactly 5 outputs; `cnt_in`=`cnt_out`=5 at `done`.
- `rst` low mid-DRAIN → all outputs return to reset values immediately and no `done` appears; a new job of N=3 then completes normally.
- With `KSC_PERF_CNT_EN`, the backpressure case → `stall_cycles`=3 at `done`.
